load_store_unit: RTL

Memory-access stage between the core's execute stage and the data RAM. It accepts one load/store request at a time and converts byte, halfword and word accesses into the RAM's word-only interface. Loads return sign- or zero-extended data. Sub-word stores use a read-modify-write sequence. Alignment is checked, and every request completes with a single-cycle response pulse.

---
 rtl/load_store_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage between execute and a word-only data RAM.
// Handles byte/half/word loads (sign or zero extended) and stores; sub-word
// stores go through a read-modify-write. One request in flight at a time.
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word
// accesses with resp_err; otherwise they are force-aligned and proceed.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both 1; req_ready is 1 only in IDLE, and req_valid is ignored
// elsewhere. resp_valid is a single-cycle pulse with no backpressure, and
// resp_rdata/resp_err are meaningful only while it is high.
module load_store_unit #(
  parameter int depth = 1024,
  localparam int AW = $clog2(depth)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          MemWrite,
  output logic          MemRead,
  output logic [AW-1:0] address,
  output logic [31:0]   write_data,
  input  logic [31:0]   read_data,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCESS   = 2'd1,
    S_MERGE_WR = 2'd2,
    S_RESP     = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t        state_q, state_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic          write_q, write_d;
  logic          uns_q, uns_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   merge_q, merge_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [1:0]    off;
  logic          err_w;
  logic [31:0]   load_ext;
  logic [31:0]   merged;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;

  // Address bits above the RAM range are intentionally dropped (address wraps).
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW+2];

  assign off = addr_q[1:0];

  // Request classification: which registered requests are rejected.
  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    err_w = (size_q == 2'b11) ||
            ((size_q == SZ_HALF) && off[0]) ||
            ((size_q == SZ_WORD) && (off != 2'b00));
`else
    err_w = (size_q == 2'b11);
`endif
  end

  // Load lane extraction and extension; half uses addr[1] only, word ignores offset.
  always_comb begin
    lane_b   = read_data[{off, 3'b000} +: 8];
    lane_h   = off[1] ? read_data[31:16] : read_data[15:0];
    load_ext = read_data;
    case (size_q)
      SZ_BYTE: load_ext = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: load_ext = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_ext = read_data;
    endcase
  end

  // Sub-word store merge: replace only the target byte/half of the latched word.
  always_comb begin
    merged = merge_q;
    if (size_q == SZ_BYTE) merged[{off, 3'b000} +: 8] = wdata_q[7:0];
    else                   merged[{off[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (req_valid) state_d = S_ACCESS;
      S_ACCESS:   state_d = (!err_w && write_q && (size_q != SZ_WORD)) ? S_MERGE_WR : S_RESP;
      S_MERGE_WR: state_d = S_RESP;
      default:    state_d = S_IDLE;
    endcase
  end

  // Datapath next values: capture request, latch load result / merge word.
  always_comb begin
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (state_q == S_IDLE && req_valid) begin
      addr_d  = req_addr[AW+1:0];
      size_d  = req_size;
      write_d = req_write;
      uns_d   = req_unsigned;
      wdata_d = req_wdata;
    end
    if (state_q == S_ACCESS) begin
      err_d   = err_w;
      rdata_d = (!err_w && !write_q) ? load_ext : 32'd0;
      if (!err_w && write_q && (size_q != SZ_WORD)) merge_d = read_data;
    end
  end

  // Outputs decoded from state; strobes drop as soon as reset forces IDLE.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    write_data = 32'd0;
    address    = (state_q == S_IDLE) ? '0 : addr_q[AW+1:2];
    dbg_state  = state_q;
    case (state_q)
      S_ACCESS: begin
        if (!err_w) begin
          if (write_q && (size_q == SZ_WORD)) begin
            MemWrite   = 1'b1;
            write_data = wdata_q;
          end else begin
            MemRead = 1'b1;
          end
        end
      end
      S_MERGE_WR: begin
        MemWrite   = 1'b1;
        write_data = merged;
      end
      default: ;
    endcase
  end

endmodule
